// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the 640x480@60 Hz VGA generator.
// Module parameters default to these values.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int       DEF_CLK_DIV     = 2;
  localparam logic     DEF_SYNC_ACTIVE = 1'b0;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  // Inclusive window test on a counter value.
  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate phase generator: one-clock pix_en pulse every other clock,
// plus a registered square wave for the DAC clock pin.
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en,
  output logic pclk
);

  logic phase;

  generate
    if (CLK_DIV != 2) begin : g_bad_clk_div
      $error("pixel_tick_gen: only CLK_DIV=2 is supported");
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) phase <= 1'b0;
    else       phase <= ~phase;
  end

  assign pix_en = phase;
  assign pclk   = phase;

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: column/row counters advanced on pix_en, with
// registered sync/blank outputs decoded from the next counter values.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV     = DEF_CLK_DIV,
  parameter int   H_VISIBLE   = DEF_H_VISIBLE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_VISIBLE   = DEF_V_VISIBLE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             h,
  output logic             v,
  output logic             bn,
  output logic             pix_en,
  output logic             pclk
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Last count of each counter must fit in CNT_W bits.
  generate
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_totals
      $error("vga_timing: H/V totals exceed the counter range");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SS_C   = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] H_SE_C   = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SS_C   = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] V_SE_C   = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] col_nxt;
  logic [CNT_W-1:0] row_nxt;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .pix_en(pix_en),
    .pclk  (pclk)
  );

  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (pix_en) begin
      if (col == H_LAST) begin
        col_nxt = '0;
        row_nxt = (row == V_LAST) ? '0 : row + 1'b1;
      end else begin
        col_nxt = col + 1'b1;
      end
    end
  end

  // Decoding the next values keeps h/v/bn aligned with the registered counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      h   <= ~SYNC_ACTIVE;
      v   <= ~SYNC_ACTIVE;
      bn  <= 1'b1;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
      h   <= in_window(col_nxt, H_SS_C, H_SE_C) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      v   <= in_window(row_nxt, V_SS_C, V_SE_C) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      bn  <= (col_nxt < H_VIS_C) && (row_nxt < V_VIS_C);
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: full 800-pixel lines with a shortened
// 13-line frame (6 visible, FP 2, sync 2, BP 3) so three frames stay short.
module tb_vga_timing;

  localparam int LINE   = 1600;
  localparam int V_VIS  = 6;
  localparam int V_FP   = 2;
  localparam int V_SYN  = 2;
  localparam int V_BP   = 3;
  localparam int V_TOT  = 13;
  localparam int FRAME  = LINE * V_TOT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] col, row;
  logic       h, v, bn, pix_en, pclk;

  int tests = 0;
  int fails = 0;

  vga_timing #(
    .V_VISIBLE(V_VIS),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYN),
    .V_BP     (V_BP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .col   (col),
    .row   (row),
    .h     (h),
    .v     (v),
    .bn    (bn),
    .pix_en(pix_en),
    .pclk  (pclk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_col"},    int'(col),    0);
    check({pfx, "_row"},    int'(row),    0);
    check({pfx, "_h"},      int'(h),      1);
    check({pfx, "_v"},      int'(v),      1);
    check({pfx, "_bn"},     int'(bn),     1);
    check({pfx, "_pix_en"}, int'(pix_en), 0);
    check({pfx, "_pclk"},   int'(pclk),   0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, r, pc, pr;
    int run_len, hold_err;
    int hlow, h_first, h_last, bn_fall;
    int vlow, bn_cnt, bn_vblank;
    int row_chg, wrap_err, frame_wraps;
    int hfalls, hper_err, last_hf, vfalls, vper_err, last_vf;
    logic prev_h, prev_v;
    int pt_a, pt_b, pt_c;
    int found, hl2;

    run_len = 1; hold_err = 0;
    hlow = 0; h_first = -1; h_last = -1; bn_fall = -1;
    vlow = 0; bn_cnt = 0; bn_vblank = 0;
    row_chg = 0; wrap_err = 0; frame_wraps = 0;
    hfalls = 0; hper_err = 0; last_hf = -1;
    vfalls = 0; vper_err = 0; last_vf = -1;
    pt_a = -1; pt_b = -1; pt_c = -1;
    found = 0; hl2 = 0;

    reset = 1'b1;
    repeat (3) step();
    check_reset_state("rst");
    reset = 1'b0;

    pc = 0; pr = 0; prev_h = 1'b1; prev_v = 1'b1;
    for (int k = 1; k <= 3 * FRAME; k++) begin
      step();
      c = int'(col);
      r = int'(row);
      if (k == 1) begin
        check("e1_col", c, 0);
        check("e1_pix_en", int'(pix_en), 1);
        check("e1_pclk", int'(pclk), 1);
      end
      if (k == 2) begin
        check("e2_col", c, 1);
        check("e2_pix_en", int'(pix_en), 0);
      end
      if (k == 3) check("e3_pix_en", int'(pix_en), 1);
      if (k == 4) check("e4_col", c, 2);

      if (k <= LINE) begin
        if (!h) begin
          hlow++;
          if (h_first < 0) h_first = c;
          h_last = c;
        end
        if (!bn && bn_fall < 0) bn_fall = c;
      end
      if (k <= FRAME) begin
        if (!v) vlow++;
        if (bn) bn_cnt++;
        if (bn && r >= V_VIS) bn_vblank++;
      end

      if (c == 639 && r == V_VIS - 1 && pt_a < 0) pt_a = int'(bn);
      if (c == 640 && r == V_VIS - 1 && pt_b < 0) pt_b = int'(bn);
      if (c == 0   && r == V_VIS     && pt_c < 0) pt_c = int'(bn);

      if (c != pc) begin
        if (run_len != 2) hold_err++;
        if (!((pc == 799 && c == 0) || (c == pc + 1))) hold_err++;
        run_len = 1;
      end else begin
        run_len++;
      end

      if (r != pr) begin
        row_chg++;
        if (pc != 799 || c != 0) wrap_err++;
        if (pr == V_TOT - 1) begin
          frame_wraps++;
          if (r != 0) wrap_err++;
        end else if (r != pr + 1) begin
          wrap_err++;
        end
      end

      if (prev_h && !h) begin
        if (last_hf >= 0 && k - last_hf != LINE) hper_err++;
        last_hf = k;
        hfalls++;
      end
      if (prev_v && !v) begin
        if (last_vf >= 0 && k - last_vf != FRAME) vper_err++;
        last_vf = k;
        vfalls++;
      end

      pc = c; pr = r; prev_h = h; prev_v = v;
    end

    check("line_h_low_clks", hlow, 192);
    check("line_h_first_col", h_first, 656);
    check("line_h_last_col", h_last, 751);
    check("line_bn_fall_col", bn_fall, 640);
    check("col_hold_errors", hold_err, 0);
    check("frame_v_low_clks", vlow, 3200);
    check("frame_bn_clks", bn_cnt, 7680);
    check("frame_bn_in_vblank", bn_vblank, 0);
    check("bn_639_lastvis", pt_a, 1);
    check("bn_640_lastvis", pt_b, 0);
    check("bn_0_firstblank", pt_c, 0);
    check("row_changes", row_chg, 3 * V_TOT);
    check("row_wrap_errors", wrap_err, 0);
    check("frame_wraps", frame_wraps, 3);
    check("hsync_falls", hfalls, 3 * V_TOT);
    check("hsync_period_errors", hper_err, 0);
    check("vsync_falls", vfalls, 3);
    check("vsync_period_errors", vper_err, 0);

    for (int i = 0; i < 2 * FRAME && found == 0; i++) begin
      step();
      if (int'(col) == 400 && int'(row) == 3) found = 1;
    end
    check("mid_frame_reached", found, 1);

    reset = 1'b1;
    step();
    check_reset_state("mid");
    reset = 1'b0;

    for (int k = 1; k <= LINE; k++) begin
      step();
      if (k == 2) check("mid_e2_col", int'(col), 1);
      if (!h) hl2++;
    end
    check("mid_line_col", int'(col), 0);
    check("mid_line_row", int'(row), 1);
    check("mid_line_h_low", hl2, 192);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
